keyled_cpu_oci_trace_arb: RTL

- Arbitrates the OCI instruction-trace word stream and the compressed data-trace stream (dct_buffer/dct_count) onto the single write port of the on-chip trace RAM.
- Owns the trace write pointer, wrap/stop policy, and the end-of-test flush that writes a terminating marker word.
- Sits between the OCI trace generators and the trace RAM inside the keyled_cpu debug module.

---
 rtl/keyled_cpu_oci_trace_arb.sv | 125 ++++++++++++
 1 files changed

// File: rtl/keyled_cpu_oci_trace_arb.sv
// Trace RAM write-port arbiter: round-robin between instruction and data trace, wrap/stop policy, end-of-test marker flush.
// Optional overflow counter output enabled by defining KEYLED_CPU_OCI_TRACE_OVF_EN.
module keyled_cpu_oci_trace_arb #(
    parameter int          TRACE_AW = 7,
    parameter logic [35:0] MARKER   = 36'hF00000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                trc_on,
    input  logic                trc_wrap,
    input  logic                trc_clr,
    input  logic                itr_valid,
    input  logic [35:0]         itr_data,
    output logic                itr_ready,
    input  logic                dct_valid,
    input  logic [29:0]         dct_buffer,
    input  logic [3:0]          dct_count,
    output logic                dct_ready,
    input  logic                test_ending,
    output logic                tw_wr,
    output logic [TRACE_AW-1:0] tw_addr,
    output logic [35:0]         tw_data,
    output logic                trc_wrapped,
    output logic                trc_done
`ifdef KEYLED_CPU_OCI_TRACE_OVF_EN
    ,
    output logic [15:0]         trc_ovf_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_FULL, S_FLUSH, S_DONE} state_t;

    state_t              state, state_next;
    logic [TRACE_AW-1:0] ptr;
    logic                prio_dct;   // 1 = data trace owns the tie-break
    logic                ptr_last;
    logic                grant_i, grant_d;

    assign ptr_last  = &ptr;
    assign itr_ready = grant_i;
    assign dct_ready = grant_d;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        unique case (state)
            S_IDLE:  if (trc_on) state_next = S_RUN;
            S_RUN: begin
                if (test_ending) begin
                    state_next = S_FLUSH;
                end else if (!trc_on) begin
                    state_next = S_IDLE;
                end else begin
                    grant_i = itr_valid && (!dct_valid || !prio_dct);
                    grant_d = dct_valid && (!itr_valid ||  prio_dct);
                    if ((grant_i || grant_d) && ptr_last && !trc_wrap)
                        state_next = S_FULL;
                end
            end
            S_FULL: begin
                if (test_ending)  state_next = S_DONE;
                else if (!trc_on) state_next = S_IDLE;
            end
            S_FLUSH: state_next = S_DONE;
            S_DONE:  if (!trc_on) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= '0;
            prio_dct    <= 1'b0;
            tw_wr       <= 1'b0;
            tw_addr     <= '0;
            tw_data     <= '0;
            trc_wrapped <= 1'b0;
            trc_done    <= 1'b0;
        end else begin
            tw_wr    <= 1'b0;
            trc_done <= (state == S_DONE) && trc_on;
            if (state == S_IDLE && trc_clr) begin
                ptr         <= '0;
                trc_wrapped <= 1'b0;
            end
            if (grant_i || grant_d) begin
                tw_wr   <= 1'b1;
                tw_addr <= ptr;
                tw_data <= grant_i ? itr_data : {2'b10, dct_count, dct_buffer};
                ptr     <= ptr + 1'b1;
                if (ptr_last && trc_wrap)
                    trc_wrapped <= 1'b1;
                // Priority only rotates on a real contention.
                if (itr_valid && dct_valid)
                    prio_dct <= grant_i;
            end
            if (state == S_FLUSH) begin
                tw_wr   <= 1'b1;
                tw_addr <= ptr;
                tw_data <= MARKER;
                ptr     <= ptr + 1'b1;
            end
        end
    end

`ifdef KEYLED_CPU_OCI_TRACE_OVF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            trc_ovf_cnt <= '0;
        else if (state == S_IDLE && trc_clr)
            trc_ovf_cnt <= '0;
        else if (state == S_FULL && (itr_valid || dct_valid) && trc_ovf_cnt != 16'hFFFF)
            trc_ovf_cnt <= trc_ovf_cnt + 16'd1;
    end
`endif

endmodule
